gpio_peer_port: RTL and testbench
=================================

// Module: gpio_peer_port
// PURPOSE
//  Pin-side counterpart of the AHB GPIO: drives the GPIO's 17-bit input word and consumes its output word.
//  TX: accepts 16-bit data on a valid/ready stream, appends a parity bit (bit 16), holds the word on gpio_in.
//  RX: detects new words on gpio_out, checks parity, queues good words in a FIFO.
//  Used as the external peer in system benches and as the loopback partner in integration.
// PARAMETERS
//  DEPTH        4   RX FIFO entries (power of 2, >=2)
//  HOLD_CYCLES  4   min cycles each TX word stays on gpio_in before the next is accepted (>=1)
//  CNT_W        8   width of saturating parity-error counter
// PORTS
//  clk           in   1      clock, all logic on rising edge
//  reset_n       in   1      asynchronous active-low reset
//  parity_sel    in   1      0 = even parity, 1 = odd parity (same sense as the GPIO's PARITYSEL)
//  gpio_out      in   17     word from GPIO GPIOOUT: [15:0] data, [16] parity
//  gpio_in       out  17     word to GPIO GPIOIN: [15:0] data, [16] parity
//  tx_data       in   16     data to send
//  tx_valid      in   1      tx_data valid
//  tx_ready      out  1      block accepts tx_data this cycle
//  rx_data       out  16     head of RX FIFO (show-ahead)
//  rx_valid      out  1      RX FIFO non-empty
//  rx_ready      in   1      pop head when rx_valid & rx_ready
//  rx_par_err    out  1      1-cycle pulse: word with bad parity detected
//  rx_err_cnt    out  CNT_W  saturating count of bad-parity words
//  rx_overflow   out  1      sticky: good word dropped because FIFO full
//  clr           in   1      sync clear of rx_err_cnt and rx_overflow
// BEHAVIOUR
//  Reset: gpio_in=0, tx_ready=1 (IDLE), rx_valid=0, rx_data=0, rx_par_err=0, rx_err_cnt=0, rx_overflow=0, prev=0.
//  Parity: par(d) = ^d ^ parity_sel; word w is good iff ^w[16:0] == parity_sel.
//  TX FSM, states IDLE/HOLD:
//   IDLE: tx_ready=1; on tx_valid, gpio_in <= {par(tx_data), tx_data} at that edge (parity_sel sampled then),
//         hold_cnt <= HOLD_CYCLES-1; HOLD if HOLD_CYCLES>1 else stay IDLE.
//   HOLD: tx_ready=0; hold_cnt decrements; at hold_cnt==0 -> IDLE next cycle. gpio_in never changes in HOLD.
//   Throughput: one word per HOLD_CYCLES cycles; gpio_in updates 0 cycles after acceptance edge.
//   parity_sel change in HOLD does not alter the held word.
//  RX:
//   prev <= gpio_out every cycle; new word when gpio_out != prev (repeat of same value is not a new word).
//   Good new word: pushed at that edge; rx_valid high next cycle (1-cycle latency).
//   Bad new word: not pushed; rx_par_err pulses next cycle; rx_err_cnt += 1, holds at all-ones.
//   Full FIFO: push accepted only if a pop occurs same cycle; otherwise word dropped, rx_overflow <= 1.
//   Empty FIFO with simultaneous push: no pop (rx_valid was 0); word visible next cycle.
//   Pointers DEPTH-wrap with extra MSB for full/empty; rx_data = mem[rd_ptr].
//   clr and bad word same cycle: counter ends at 1. clr and overflow same cycle: rx_overflow ends at 1.
//  Reset asserted mid-operation: all state to reset values immediately; FIFO contents discarded.
// STRUCTURE
//  gpio_pkg: GPIO_DW=16, GPIO_W=17, typedef gpio_word_t (packed {par, data}), function gpio_par(data, sel).
//  Sub-module gpio_peer_fifo (DEPTH, 16-bit, push/pop/full/empty, show-ahead); TX FSM and RX checker inline.
// TESTING
//  1 Reset: reset_n=0 mid-TX HOLD and with 2 RX entries -> gpio_in=0, tx_ready=1, rx_valid=0, counters 0.
//  2 TX even: parity_sel=0, tx_data=16'h0003 -> gpio_in=17'h00003; tx_data=16'h0001 -> 17'h10001;
//    tx_valid held high: accepts spaced exactly HOLD_CYCLES=4 apart.
//  3 TX odd: parity_sel=1, tx_data=16'h0000 -> gpio_in=17'h10000.
//  4 RX good/bad: parity_sel=0, gpio_out=17'h00003 -> rx_data=16'h0003 next cycle;
//    gpio_out=17'h10003 -> rx_par_err pulse, rx_err_cnt=1, no push; 300 bad words -> cnt=255.
//  5 Overflow: rx_ready=0, 5 distinct good words (DEPTH=4) -> 4 queued, rx_overflow=1; push+pop on full -> no drop.
//  6 Loopback: gpio_out tied to gpio_in, 8 random words -> identical RX sequence, rx_err_cnt=0.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: shared word layout, parity helper and TX FSM encoding for the GPIO peer port.
package gpio_pkg;

    localparam int GPIO_DW = 16;
    localparam int GPIO_W  = 17;

    localparam logic [0:0] TX_IDLE = 1'b0;
    localparam logic [0:0] TX_HOLD = 1'b1;

    typedef struct packed {
        logic               par;
        logic [GPIO_DW-1:0] data;
    } gpio_word_t;

    function automatic logic gpio_par(input logic [GPIO_DW-1:0] data, input logic sel);
        return ^data ^ sel;
    endfunction

endpackage

// File: rtl/gpio_peer_fifo.sv
// gpio_peer_fifo: show-ahead RX FIFO; the caller qualifies push/pop against full/empty.
module gpio_peer_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Extra pointer MSB separates full from empty when the indices match.
    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/gpio_peer_port.sv
// gpio_peer_port: pin-side GPIO peer; TX holds parity-tagged words on gpio_in,
// RX detects changes on gpio_out, checks parity and queues good words.
module gpio_peer_port
    import gpio_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                parity_sel,
    input  logic [GPIO_W-1:0]   gpio_out,
    output logic [GPIO_W-1:0]   gpio_in,
    input  logic [GPIO_DW-1:0]  tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [GPIO_DW-1:0]  rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                rx_par_err,
    output logic [CNT_W-1:0]    rx_err_cnt,
    output logic                rx_overflow,
    input  logic                clr
);

    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;

    logic [0:0]        state;
    logic [HW-1:0]     hold_cnt;
    gpio_word_t        word_q;

    assign gpio_in  = word_q;
    assign tx_ready = state == TX_IDLE;

    // Leaving HOLD as the count reaches zero gives exactly HOLD_CYCLES between accepts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= TX_IDLE;
            hold_cnt <= '0;
            word_q   <= '0;
        end else if (state == TX_IDLE) begin
            if (tx_valid) begin
                word_q   <= '{par: gpio_par(tx_data, parity_sel), data: tx_data};
                hold_cnt <= HW'(HOLD_CYCLES - 1);
                state    <= HOLD_CYCLES > 1 ? TX_HOLD : TX_IDLE;
            end
        end else begin
            hold_cnt <= hold_cnt - 1'b1;
            if (hold_cnt == HW'(1)) state <= TX_IDLE;
        end
    end

    logic [GPIO_W-1:0] prev;
    logic new_word, good, bad, pop, push, drop, full, empty;

    assign new_word = gpio_out != prev;
    assign good     = (^gpio_out) == parity_sel;
    assign bad      = new_word & ~good;
    assign pop      = rx_valid & rx_ready;
    assign push     = new_word & good & (~full | pop);
    assign drop     = new_word & good & full & ~pop;
    assign rx_valid = ~empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev        <= '0;
            rx_par_err  <= 1'b0;
            rx_err_cnt  <= '0;
            rx_overflow <= 1'b0;
        end else begin
            prev        <= gpio_out;
            rx_par_err  <= bad;
            rx_err_cnt  <= clr ? CNT_W'(bad) :
                           (bad && rx_err_cnt != '1) ? rx_err_cnt + 1'b1 : rx_err_cnt;
            rx_overflow <= clr ? drop : rx_overflow | drop;
        end
    end

    gpio_peer_fifo #(.DEPTH(DEPTH), .W(GPIO_DW)) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (push),
        .wdata  (gpio_out[GPIO_DW-1:0]),
        .pop    (pop),
        .rdata  (rx_data),
        .full   (full),
        .empty  (empty)
    );

endmodule

// File: tb/tb_gpio_peer_port.sv
// tb_gpio_peer_port: directed and random stimulus against a queue-based reference model.
module tb_gpio_peer_port;

    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int CW    = 8;
    localparam int CMAX  = (1 << CW) - 1;

    logic        clk = 0, reset_n = 0, parity_sel = 0, tx_valid = 0, rx_ready = 0, clr = 0, loop = 0;
    logic [16:0] gpio_drv = '0;
    logic [15:0] tx_data = '0;
    logic [16:0] gpio_out, gpio_in;
    logic        tx_ready, rx_valid, rx_par_err, rx_overflow;
    logic [15:0] rx_data;
    logic [CW-1:0] rx_err_cnt;

    assign gpio_out = loop ? gpio_in : gpio_drv;

    gpio_peer_port #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .parity_sel(parity_sel), .gpio_out(gpio_out), .gpio_in(gpio_in),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_par_err(rx_par_err),
        .rx_err_cnt(rx_err_cnt), .rx_overflow(rx_overflow), .clr(clr)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    logic [15:0] m_q[$], sent[$], rcv[$];
    int dut_acc[$];
    logic [16:0] m_prev, m_gin;
    int m_wait, m_cnt;
    bit m_ovf, m_perr;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [16:0] mk(logic [15:0] d, logic s, bit corrupt);
        logic p;
        p = (($countones(d) + int'(s) + int'(corrupt)) % 2) == 1;
        return {p, d};
    endfunction

    task automatic model_reset;
        m_q.delete();
        m_prev = '0; m_gin = '0; m_wait = 0; m_cnt = 0; m_ovf = 0; m_perr = 0;
    endtask

    task automatic check_all;
        check("gpio_in", gpio_in, m_gin);
        check("tx_ready", tx_ready, m_wait == 0);
        check("rx_valid", rx_valid, m_q.size() != 0);
        if (m_q.size() != 0) check("rx_data", rx_data, m_q[0]);
        check("rx_par_err", rx_par_err, m_perr);
        check("rx_err_cnt", rx_err_cnt, m_cnt);
        check("rx_overflow", rx_overflow, m_ovf);
    endtask

    task automatic tick;
        logic [16:0] go;
        logic [15:0] td;
        logic ps;
        bit acc, pop, nw, good, drop, cl;
        go   = loop ? m_gin : gpio_drv;
        td   = tx_data; ps = parity_sel; cl = clr;
        acc  = tx_valid && m_wait == 0;
        pop  = rx_ready && m_q.size() > 0;
        nw   = go != m_prev;
        good = ($countones(go) % 2) == int'(parity_sel);
        drop = nw && good && m_q.size() == DEPTH && !pop;
        if (tx_valid && tx_ready) dut_acc.push_back(cyc);
        if (loop && rx_valid && rx_ready) rcv.push_back(rx_data);
        @(posedge clk); #1;
        cyc++;
        if (pop) void'(m_q.pop_front());
        if (nw && good && !drop) m_q.push_back(go[15:0]);
        m_perr = nw && !good;
        m_cnt  = cl ? int'(m_perr) : ((m_perr && m_cnt < CMAX) ? m_cnt + 1 : m_cnt);
        m_ovf  = cl ? drop : (m_ovf | drop);
        m_prev = go;
        if (acc) begin
            m_gin  = mk(td, ps, 0);
            m_wait = HOLD - 1;
            if (loop) sent.push_back(td);
        end else if (m_wait > 0) m_wait--;
        check_all();
    endtask

    task automatic do_reset;
        reset_n = 0;
        #3;
        model_reset();
        check_all();
        check("rst_rx_data", rx_data, 16'h0);
        check("rst_tx_ready", tx_ready, 1'b1);
        @(posedge clk); #1;
        reset_n = 1;
    endtask

    initial begin
        int n;
        logic [15:0] d, last;
        do_reset();

        // TX even parity, back-to-back accepts with tx_valid held high
        dut_acc.delete();
        parity_sel = 0; tx_data = 16'h0003; tx_valid = 1;
        tick();
        check("tx_even_3", gpio_in, 17'h00003);
        tx_data = 16'h0001;
        repeat (HOLD) tick();
        check("tx_even_1", gpio_in, 17'h10001);
        check("tx_acc_n", dut_acc.size(), 2);
        if (dut_acc.size() >= 2) check("tx_spacing", dut_acc[1] - dut_acc[0], HOLD);
        tx_valid = 0;
        repeat (HOLD) tick();

        // TX odd parity; parity_sel flips while holding
        parity_sel = 1; tx_data = 16'h0000; tx_valid = 1;
        tick();
        tx_valid = 0; parity_sel = 0;
        check("tx_odd_0", gpio_in, 17'h10000);
        repeat (HOLD) tick();
        check("tx_hold_keep", gpio_in, 17'h10000);

        // RX good and bad words, counter saturation, clr interaction
        gpio_drv = 17'h00003;
        tick();
        check("rx_good_v", rx_valid, 1'b1);
        check("rx_good_d", rx_data, 16'h0003);
        gpio_drv = 17'h10003;
        tick();
        check("rx_bad_pulse", rx_par_err, 1'b1);
        check("rx_bad_cnt", rx_err_cnt, 1);
        tick();
        check("rx_pulse_end", rx_par_err, 1'b0);
        rx_ready = 1; tick(); rx_ready = 0;
        for (int i = 0; i < 300; i++) begin
            gpio_drv = mk(16'h2000 + 16'(i), 0, 1);
            tick();
        end
        check("rx_cnt_sat", rx_err_cnt, 8'hff);
        clr = 1; gpio_drv = mk(16'h3000, 0, 1);
        tick();
        check("clr_bad_cnt", rx_err_cnt, 1);
        tick();
        clr = 0;
        check("clr_cnt", rx_err_cnt, 0);

        // Overflow, push+pop on full, clr with overflow
        for (int i = 0; i < 5; i++) begin
            gpio_drv = mk(16'h4000 + 16'(i), 0, 0);
            tick();
        end
        check("ovf_set", rx_overflow, 1'b1);
        check("ovf_head", rx_data, 16'h4000);
        rx_ready = 1; gpio_drv = mk(16'h4010, 0, 0);
        tick();
        rx_ready = 0;
        check("full_pp_ovf", rx_overflow, 1'b1);
        check("full_pp_head", rx_data, 16'h4001);
        clr = 1; gpio_drv = mk(16'h4011, 0, 0);
        tick();
        check("clr_ovf_drop", rx_overflow, 1'b1);
        tick();
        clr = 0;
        check("clr_ovf", rx_overflow, 1'b0);
        rx_ready = 1;
        repeat (DEPTH + 1) tick();
        check("drained", rx_valid, 1'b0);
        rx_ready = 0;

        // Reset mid-HOLD with two RX entries queued
        gpio_drv = mk(16'h5001, 0, 0); tick();
        gpio_drv = mk(16'h5002, 0, 0); tick();
        tx_data = 16'h00a5; tx_valid = 1; tick();
        tx_valid = 0; tick();
        check("pre_rst_hold", tx_ready, 1'b0);
        check("pre_rst_q", rx_valid, 1'b1);
        #2;
        do_reset();
        check("rst_gpio_in", gpio_in, 17'h0);
        check("rst_rx_valid", rx_valid, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            tx_valid = 1'($urandom % 2);
            tx_data  = 16'($urandom);
            rx_ready = ($urandom % 4) != 0;
            if ($urandom % 3 != 0) gpio_drv = 17'($urandom) & 17'h1000f;
            if ($urandom % 16 == 0) parity_sel = ~parity_sel;
            clr = ($urandom % 32) == 0;
            tick();
        end
        clr = 0; tx_valid = 0;

        // Loopback
        loop = 1; parity_sel = 1'($urandom % 2); rx_ready = 1;
        do_reset();
        sent.delete(); rcv.delete();
        last = '0;
        for (int w = 0; w < 8; w++) begin
            do d = 16'($urandom); while (d == last);
            last = d;
            tx_data = d; tx_valid = 1;
            n = sent.size();
            for (int k = 0; k < 3 * HOLD && sent.size() == n; k++) tick();
            tx_valid = 0;
        end
        repeat (HOLD + 4) tick();
        check("lb_sent", sent.size(), 8);
        check("lb_rcv", rcv.size(), sent.size());
        for (int i = 0; i < sent.size() && i < rcv.size(); i++) check("lb_word", rcv[i], sent[i]);
        check("lb_err_cnt", rx_err_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
